t05_header_decode: RTL and testbench

//  Receive end of the Huffman header bit stream. Consumes one serial header bit per

---
 rtl/t05_header_pkg.sv | 21 ++
 rtl/t05_last_zero_finder.sv | 24 ++
 rtl/t05_header_decode.sv | 168 ++++++++++++++++
 tb/tb_t05_header_decode.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/t05_header_pkg.sv
// Constants and state encoding shared by the Huffman header transmitter and receiver.
// The tree is walked in preorder: '0' = internal node, '1' + SYM_W bits = leaf.
package t05_header_pkg;

  localparam int SYM_W         = 8;
  localparam int BITCNT_W      = $clog2(SYM_W);
  localparam int DEF_MAX_DEPTH = 127;
  localparam int DEF_DEPTH_W   = 7;
  localparam int MAX_LEAVES    = 256;
  localparam int LCNT_W        = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NODE,
    ST_SYM,
    ST_EMIT,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/t05_last_zero_finder.sv
// Highest-index zero among path bits below depth; drives the preorder backtrack.
// Single-cycle combinational priority encoder, higher index wins.
module t05_last_zero_finder #(
  parameter int MAX_DEPTH = 127,
  parameter int DEPTH_W   = 7
) (
  input  logic [MAX_DEPTH-1:0] i_path,
  input  logic [DEPTH_W-1:0]   i_depth,
  output logic                 o_found,
  output logic [DEPTH_W-1:0]   o_index
);

  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    for (int k = 0; k < MAX_DEPTH; k++) begin
      if ((DEPTH_W'(k) < i_depth) && !i_path[k]) begin
        o_found = 1'b1;
        o_index = DEPTH_W'(k);
      end
    end
  end

endmodule

// File: rtl/t05_header_decode.sv
// Receive side of the Huffman header: rebuilds the tree from the serial preorder
// stream and emits one (symbol, code, length) record per leaf.
module t05_header_decode
  import t05_header_pkg::*;
#(
  parameter int MAX_DEPTH = DEF_MAX_DEPTH,
  parameter int DEPTH_W   = DEF_DEPTH_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic                 bit_ready,
  output logic                 sym_valid,
  output logic [SYM_W-1:0]     sym,
  output logic [MAX_DEPTH-1:0] code,
  output logic [DEPTH_W-1:0]   code_len,
  output logic [LCNT_W-1:0]    leaf_count,
  output logic                 done,
  output logic                 error
);

  state_t                r_state, w_state_nxt;
  logic [MAX_DEPTH-1:0]  r_path;
  logic [DEPTH_W-1:0]    r_depth;
  logic [SYM_W-2:0]      r_shreg;
  logic [BITCNT_W-1:0]   r_bitcnt;
  logic                  r_sym_valid;
  logic [SYM_W-1:0]      r_sym;
  logic [MAX_DEPTH-1:0]  r_code;
  logic [DEPTH_W-1:0]    r_code_len;
  logic [LCNT_W-1:0]     r_leaf_count;

  logic                  w_xfer;
  logic                  w_at_max;
  logic                  w_last_bit;
  logic                  w_leaf_full;
  logic                  w_bt_found;
  logic [DEPTH_W-1:0]    w_bt_idx;
  logic [MAX_DEPTH-1:0]  w_len_mask;
  logic [MAX_DEPTH-1:0]  w_path_bt;

  assign bit_ready   = (r_state == ST_NODE) || (r_state == ST_SYM);
  assign w_xfer      = bit_valid && bit_ready;
  assign w_at_max    = (r_depth == DEPTH_W'(MAX_DEPTH));
  assign w_last_bit  = (r_bitcnt == BITCNT_W'(SYM_W - 1));
  assign w_leaf_full = (r_leaf_count == LCNT_W'(MAX_LEAVES));

  assign sym_valid  = r_sym_valid;
  assign sym        = r_sym;
  assign code       = r_code;
  assign code_len   = r_code_len;
  assign leaf_count = r_leaf_count;
  assign done       = (r_state == ST_DONE);
  assign error      = (r_state == ST_ERR);

  t05_last_zero_finder #(
    .MAX_DEPTH (MAX_DEPTH),
    .DEPTH_W   (DEPTH_W)
  ) u_finder (
    .i_path  (r_path),
    .i_depth (r_depth),
    .o_found (w_bt_found),
    .o_index (w_bt_idx)
  );

  // Backtrack target: keep bits below k, flip bit k to the right branch, drop the rest.
  always_comb begin
    w_len_mask = '0;
    w_path_bt  = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      w_len_mask[i] = (DEPTH_W'(i) < r_depth);
      if (DEPTH_W'(i) < w_bt_idx)
        w_path_bt[i] = r_path[i];
      else
        w_path_bt[i] = (DEPTH_W'(i) == w_bt_idx);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = ST_NODE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_NODE: begin
          if (w_xfer) begin
            if (bit_in)        w_state_nxt = ST_SYM;
            else if (w_at_max) w_state_nxt = ST_ERR;
          end
        end
        ST_SYM: begin
          if (w_xfer && w_last_bit)
            w_state_nxt = w_leaf_full ? ST_ERR : ST_EMIT;
        end
        ST_EMIT: w_state_nxt = w_bt_found ? ST_NODE : ST_DONE;
        ST_DONE: w_state_nxt = ST_DONE;
        ST_ERR:  w_state_nxt = ST_ERR;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Record outputs load on the 8th symbol bit so they are visible during EMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_path       <= '0;
      r_depth      <= '0;
      r_shreg      <= '0;
      r_bitcnt     <= '0;
      r_sym_valid  <= 1'b0;
      r_sym        <= '0;
      r_code       <= '0;
      r_code_len   <= '0;
      r_leaf_count <= '0;
    end else begin
      r_sym_valid <= 1'b0;
      if (start) begin
        r_path       <= '0;
        r_depth      <= '0;
        r_bitcnt     <= '0;
        r_leaf_count <= '0;
      end else begin
        case (r_state)
          ST_NODE: begin
            if (w_xfer) begin
              if (bit_in) begin
                r_bitcnt <= '0;
              end else if (!w_at_max) begin
                for (int i = 0; i < MAX_DEPTH; i++)
                  if (DEPTH_W'(i) == r_depth) r_path[i] <= 1'b0;
                r_depth <= r_depth + 1'b1;
              end
            end
          end
          ST_SYM: begin
            if (w_xfer) begin
              r_shreg  <= {r_shreg[SYM_W-3:0], bit_in};
              r_bitcnt <= r_bitcnt + 1'b1;
              if (w_last_bit && !w_leaf_full) begin
                r_sym_valid  <= 1'b1;
                r_sym        <= {r_shreg, bit_in};
                r_code       <= r_path & w_len_mask;
                r_code_len   <= r_depth;
                r_leaf_count <= r_leaf_count + 1'b1;
              end
            end
          end
          ST_EMIT: begin
            if (w_bt_found) begin
              r_path  <= w_path_bt;
              r_depth <= w_bt_idx + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_t05_header_decode.sv
// Directed bench for the header decoder: preorder streams with hand-derived records,
// depth overflow on a 4-deep instance, stream gaps, restart and async reset.
module tb_t05_header_decode;
  import t05_header_pkg::*;

  localparam int MD  = 127;
  localparam int DW  = 7;
  localparam int MD4 = 4;
  localparam int DW4 = 3;

  logic clk = 1'b0;
  logic rst, start, bit_in, bit_valid;

  logic           bit_ready, sym_valid, done, error;
  logic [7:0]     sym;
  logic [MD-1:0]  code;
  logic [DW-1:0]  code_len;
  logic [8:0]     leaf_count;

  logic           bit_ready4, sym_valid4, done4, error4;
  logic [7:0]     sym4;
  logic [MD4-1:0] code4;
  logic [DW4-1:0] code_len4;
  logic [8:0]     leaf_count4;

  t05_header_decode #(.MAX_DEPTH(MD), .DEPTH_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .sym_valid(sym_valid), .sym(sym), .code(code),
    .code_len(code_len), .leaf_count(leaf_count), .done(done), .error(error)
  );

  t05_header_decode #(.MAX_DEPTH(MD4), .DEPTH_W(DW4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready4), .sym_valid(sym_valid4), .sym(sym4), .code(code4),
    .code_len(code_len4), .leaf_count(leaf_count4), .done(done4), .error(error4)
  );

  always #5 clk = ~clk;

  int   vec  = 0;
  int   errs = 0;
  int   viol = 0;
  logic sel4 = 1'b0;

  typedef struct {
    logic [7:0]    s;
    logic [MD-1:0] c;
    logic [DW-1:0] l;
  } rec_t;
  rec_t q[$];
  rec_t mon_r;

  always @(negedge clk) begin
    if (sym_valid === 1'b1) begin
      mon_r.s = sym;
      mon_r.c = code;
      mon_r.l = code_len;
      q.push_back(mon_r);
      if (bit_ready !== 1'b0) viol++;
    end
  end

  task automatic send_bit(input logic b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin @(negedge clk); bit_valid = 1'b0; end
    @(negedge clk); bit_valid = 1'b1; bit_in = b; n = 0;
    while (((sel4 ? bit_ready4 : bit_ready) !== 1'b1) && n < 40) begin
      @(negedge clk); n++;
    end
    if (n >= 40) begin
      vec++; errs++; bit_valid = 1'b0;
      $display("FAIL send_bit timeout: bit_ready got 0 exp 1");
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input int max_gap);
    for (int i = 7; i >= 0; i--)
      send_bit(v[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  task automatic idle();
    @(negedge clk); bit_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic inflight);
    @(negedge clk); start = 1'b1; bit_valid = inflight; bit_in = 1'b0;
    @(negedge clk); start = 1'b0; bit_valid = 1'b0;
  endtask

  task automatic test_reset();
    vec++; if ({sym_valid, done, error, bit_ready} !== 4'b0) begin
      errs++; $display("FAIL reset flags: got %b exp 0000", {sym_valid, done, error, bit_ready}); end
    vec++; if (sym !== 8'h00) begin errs++; $display("FAIL reset sym: got %h exp 00", sym); end
    vec++; if (code !== '0) begin errs++; $display("FAIL reset code: got %h exp 0", code); end
    vec++; if (code_len !== '0) begin errs++; $display("FAIL reset code_len: got %0d exp 0", code_len); end
    vec++; if (leaf_count !== 9'd0) begin errs++; $display("FAIL reset leaf_count: got %0d exp 0", leaf_count); end
    vec++; if ({error4, bit_ready4, sym_valid4} !== 3'b0) begin
      errs++; $display("FAIL reset dut4 flags: got %b exp 000", {error4, bit_ready4, sym_valid4}); end
  endtask

  task automatic test_idle();
    @(negedge clk); bit_valid = 1'b1; bit_in = 1'b1;
    repeat (3) @(negedge clk);
    vec++; if (bit_ready !== 1'b0) begin errs++; $display("FAIL idle bit_ready: got %b exp 0", bit_ready); end
    vec++; if ({sym_valid, done, error} !== 3'b0) begin
      errs++; $display("FAIL idle flags: got %b exp 000", {sym_valid, done, error}); end
    bit_valid = 1'b0;
  endtask

  task automatic test_two_leaf();
    int base;
    logic [7:0] es[2]; logic [MD-1:0] ec[2]; logic [DW-1:0] el[2];
    es[0] = 8'h41; ec[0] = '0;     el[0] = 7'd1;
    es[1] = 8'h42; ec[1] = MD'(1); el[1] = 7'd1;
    pulse_start(1'b0); base = q.size();
    send_bit(1'b0, 0); send_bit(1'b1, 0); send_byte(8'h41, 0);
    send_bit(1'b1, 0); send_byte(8'h42, 0);
    idle(); @(negedge clk);
    vec++; if (q.size() - base !== 2) begin
      errs++; $display("FAIL two_leaf count: got %0d exp 2", q.size() - base); end
    else for (int i = 0; i < 2; i++) begin
      vec++; if (q[base+i].s !== es[i] || q[base+i].c !== ec[i] || q[base+i].l !== el[i]) begin
        errs++; $display("FAIL two_leaf rec%0d: got %h/%h/%0d exp %h/%h/%0d", i,
                         q[base+i].s, q[base+i].c, q[base+i].l, es[i], ec[i], el[i]); end
    end
    vec++; if (done !== 1'b1) begin errs++; $display("FAIL two_leaf done: got %b exp 1", done); end
    vec++; if (leaf_count !== 9'd2) begin errs++; $display("FAIL two_leaf leaf_count: got %0d exp 2", leaf_count); end
    vec++; if (error !== 1'b0) begin errs++; $display("FAIL two_leaf error: got %b exp 0", error); end
  endtask

  task automatic test_three_leaf(input int max_gap, input string tag);
    int base, v0;
    logic [7:0] es[3]; logic [MD-1:0] ec[3]; logic [DW-1:0] el[3];
    es[0] = 8'h61; ec[0] = '0;     el[0] = 7'd2;
    es[1] = 8'h62; ec[1] = MD'(2); el[1] = 7'd2;
    es[2] = 8'h63; ec[2] = MD'(1); el[2] = 7'd1;
    pulse_start(1'b0); base = q.size(); v0 = viol;
    send_bit(1'b0, max_gap); send_bit(1'b0, max_gap); send_bit(1'b1, max_gap);
    send_byte(8'h61, max_gap); send_bit(1'b1, max_gap);
    send_byte(8'h62, max_gap); send_bit(1'b1, max_gap); send_byte(8'h63, max_gap);
    idle(); @(negedge clk);
    vec++; if (q.size() - base !== 3) begin
      errs++; $display("FAIL %s count: got %0d exp 3", tag, q.size() - base); end
    else for (int i = 0; i < 3; i++) begin
      vec++; if (q[base+i].s !== es[i] || q[base+i].c !== ec[i] || q[base+i].l !== el[i]) begin
        errs++; $display("FAIL %s rec%0d: got %h/%h/%0d exp %h/%h/%0d", tag, i,
                         q[base+i].s, q[base+i].c, q[base+i].l, es[i], ec[i], el[i]); end
    end
    vec++; if (done !== 1'b1) begin errs++; $display("FAIL %s done: got %b exp 1", tag, done); end
    vec++; if (leaf_count !== 9'd3) begin errs++; $display("FAIL %s leaf_count: got %0d exp 3", tag, leaf_count); end
    vec++; if (bit_ready !== 1'b0) begin errs++; $display("FAIL %s ready in DONE: got %b exp 0", tag, bit_ready); end
    vec++; if (viol - v0 !== 0) begin errs++; $display("FAIL %s ready in EMIT: got %0d exp 0", tag, viol - v0); end
  endtask

  task automatic test_single_leaf();
    pulse_start(1'b0);
    send_bit(1'b1, 0); send_byte(8'h7A, 0);
    idle();
    vec++; if (sym_valid !== 1'b1) begin errs++; $display("FAIL single sym_valid: got %b exp 1", sym_valid); end
    vec++; if (sym !== 8'h7A) begin errs++; $display("FAIL single sym: got %h exp 7a", sym); end
    vec++; if (code_len !== 7'd0 || code !== '0) begin
      errs++; $display("FAIL single code: got %h/%0d exp 0/0", code, code_len); end
    vec++; if ({done, bit_ready} !== 2'b00) begin
      errs++; $display("FAIL single emit done/ready: got %b exp 00", {done, bit_ready}); end
    @(negedge clk);
    vec++; if ({done, sym_valid} !== 2'b10) begin
      errs++; $display("FAIL single done/sym_valid: got %b exp 10", {done, sym_valid}); end
    vec++; if (leaf_count !== 9'd1) begin errs++; $display("FAIL single leaf_count: got %0d exp 1", leaf_count); end
    vec++; if (sym !== 8'h7A) begin errs++; $display("FAIL single sym hold: got %h exp 7a", sym); end
  endtask

  task automatic test_max_depth();
    sel4 = 1'b1;
    pulse_start(1'b0);
    repeat (4) send_bit(1'b0, 0);
    idle();
    vec++; if ({error4, bit_ready4} !== 2'b01) begin
      errs++; $display("FAIL maxdepth 4th error/ready: got %b exp 01", {error4, bit_ready4}); end
    send_bit(1'b0, 0);
    idle();
    vec++; if (error4 !== 1'b1) begin errs++; $display("FAIL maxdepth error: got %b exp 1", error4); end
    vec++; if (bit_ready4 !== 1'b0) begin errs++; $display("FAIL maxdepth bit_ready: got %b exp 0", bit_ready4); end
    vec++; if ({sym_valid4, done4} !== 2'b00 || leaf_count4 !== 9'd0) begin
      errs++; $display("FAIL maxdepth no leaf: got %b/%0d exp 00/0", {sym_valid4, done4}, leaf_count4); end
    sel4 = 1'b0;
  endtask

  task automatic test_start_mid();
    int base;
    pulse_start(1'b0); base = q.size();
    send_bit(1'b0, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
    pulse_start(1'b1);
    send_bit(1'b0, 0); send_bit(1'b1, 0); send_byte(8'h41, 0);
    send_bit(1'b1, 0); send_byte(8'h42, 0);
    idle(); @(negedge clk);
    vec++; if (q.size() - base !== 2) begin
      errs++; $display("FAIL restart count: got %0d exp 2", q.size() - base); end
    else begin
      vec++; if (q[base].s !== 8'h41 || q[base].c !== '0 || q[base].l !== 7'd1) begin
        errs++; $display("FAIL restart rec0: got %h/%h/%0d exp 41/0/1", q[base].s, q[base].c, q[base].l); end
      vec++; if (q[base+1].s !== 8'h42 || q[base+1].c !== MD'(1) || q[base+1].l !== 7'd1) begin
        errs++; $display("FAIL restart rec1: got %h/%h/%0d exp 42/1/1", q[base+1].s, q[base+1].c, q[base+1].l); end
    end
    vec++; if ({done, leaf_count} !== {1'b1, 9'd2}) begin
      errs++; $display("FAIL restart done/leaf_count: got %b/%0d exp 1/2", done, leaf_count); end
  endtask

  task automatic test_async_reset();
    pulse_start(1'b0);
    send_bit(1'b0, 0); send_bit(1'b1, 0); send_byte(8'h41, 0); send_bit(1'b1, 0);
    send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
    idle();
    vec++; if ({leaf_count, bit_ready} !== {9'd1, 1'b1}) begin
      errs++; $display("FAIL arst pre leaf_count/ready: got %0d/%b exp 1/1", leaf_count, bit_ready); end
    #2 rst = 1'b1;
    #1;
    vec++; if ({sym_valid, done, error, bit_ready} !== 4'b0) begin
      errs++; $display("FAIL arst flags: got %b exp 0000", {sym_valid, done, error, bit_ready}); end
    vec++; if (sym !== 8'h00 || code !== '0 || code_len !== '0 || leaf_count !== 9'd0) begin
      errs++; $display("FAIL arst record: got %h/%h/%0d/%0d exp 0/0/0/0", sym, code, code_len, leaf_count); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    vec++; if (bit_ready !== 1'b0) begin errs++; $display("FAIL arst idle ready: got %b exp 0", bit_ready); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_idle();
    test_two_leaf();
    test_three_leaf(0, "tree3");
    test_single_leaf();
    test_max_depth();
    test_three_leaf(3, "gaps");
    test_start_mid();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
